// File: rtl/fp_round_pkg.sv
// Shared definitions for the floating-point rounding pipeline: rounding-mode
// encodings, flag bit positions and the canonical quiet-NaN constructor.
package fp_round_pkg;

    typedef enum logic [2:0] {
        RM_RNE = 3'b000,
        RM_RTZ = 3'b001,
        RM_RDN = 3'b010,
        RM_RUP = 3'b011,
        RM_RMM = 3'b100
    } rm_e;

    localparam int unsigned FLAG_NV = 4;
    localparam int unsigned FLAG_DZ = 3;
    localparam int unsigned FLAG_OF = 2;
    localparam int unsigned FLAG_UF = 1;
    localparam int unsigned FLAG_NX = 0;

    typedef logic [4:0] flags_t;

    localparam int unsigned MAX_FP_W = 128;

    // Canonical qNaN {0, all-ones exp, man MSB set}, right-aligned in a wide vector.
    function automatic logic [MAX_FP_W-1:0] qnan(input int unsigned exp_w,
                                                 input int unsigned man_w);
        logic [MAX_FP_W-1:0] v;
        v = '0;
        for (int unsigned i = man_w; i < man_w + exp_w; i++) begin
            v[i] = 1'b1;
        end
        v[man_w-1] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/fp_round_incr.sv
// Combinational round-increment decision for a normalised mantissa given
// guard/round/sticky bits and the rounding mode.
module fp_round_incr
    import fp_round_pkg::*;
(
    input  logic       sign_i,
    input  logic       lsb_i,
    input  logic [2:0] grs_i,
    input  logic [2:0] rm_i,
    output logic       incr_o
);

    logic guard;
    logic inexact;

    assign guard   = grs_i[2];
    assign inexact = |grs_i;

    always_comb begin
        incr_o = 1'b0;
        case (rm_i)
            RM_RNE:  incr_o = guard & (grs_i[1] | grs_i[0] | lsb_i);
            RM_RTZ:  incr_o = 1'b0;
            RM_RDN:  incr_o = inexact & sign_i;
            RM_RUP:  incr_o = inexact & ~sign_i;
            RM_RMM:  incr_o = guard;
            default: incr_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/fp_round_pipe.sv
// Two-stage rounding pipeline: S1 registers the operand and increment decision,
// S2 registers the rounded result. Flags exist only with FP_ROUND_PIPE_FLAGS_EN.
module fp_round_pipe
    import fp_round_pkg::*;
#(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic                     sign_i,
    input  logic [EXP_W-1:0]         exp_i,
    input  logic [MAN_W-1:0]         man_i,
    input  logic [2:0]               grs_i,
    input  logic [2:0]               rm_i,
    input  logic                     flush_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [EXP_W+MAN_W:0]     result_o,
    output logic [4:0]               flags_o
);

    localparam int unsigned W = 1 + EXP_W + MAN_W;
    localparam logic [MAX_FP_W-1:0] QNAN_FULL = qnan(EXP_W, MAN_W);
    localparam logic [W-1:0] QNAN = QNAN_FULL[W-1:0];
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [EXP_W-1:0] EXP_MAX_FIN = {{(EXP_W-1){1'b1}}, 1'b0};
    localparam logic [MAN_W-1:0] MAN_ONES = '1;

    logic s1_v, s2_v;
    logic s1_en, s2_en, s1_load, s2_load;

    logic             s1_sign;
    logic [EXP_W-1:0] s1_exp;
    logic [MAN_W-1:0] s1_man;
    logic [2:0]       s1_rm;
    logic             s1_g;
    logic             s1_incr;
    logic             incr;

    logic [W-1:0]     s2_res;
    logic [W-1:0]     res_d;

    logic [MAN_W:0]   man_sum;
    logic [EXP_W-1:0] exp_sum;
    logic             rm_bad;
    logic             special;
    logic             ovf;
    logic             to_max;

    assign s2_en   = ~s2_v | ready_i;
    assign s1_en   = ~s1_v | s2_en;
    assign ready_o = s1_en;
    assign s1_load = s1_en & valid_i;
    assign s2_load = s2_en & s1_v;

    fp_round_incr u_incr (
        .sign_i (sign_i),
        .lsb_i  (man_i[0]),
        .grs_i  (grs_i),
        .rm_i   (rm_i),
        .incr_o (incr)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
        end else begin
            s1_v <= flush_i ? 1'b0 : (s1_en ? valid_i : s1_v);
            s2_v <= flush_i ? 1'b0 : (s2_en ? s1_v : s2_v);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_sign <= 1'b0;
            s1_exp  <= '0;
            s1_man  <= '0;
            s1_rm   <= '0;
            s1_g    <= 1'b0;
            s1_incr <= 1'b0;
        end else if (s1_load) begin
            s1_sign <= sign_i;
            s1_exp  <= exp_i;
            s1_man  <= man_i;
            s1_rm   <= rm_i;
            s1_g    <= grs_i[2];
            s1_incr <= incr;
        end
    end

    always_comb begin
        man_sum = {1'b0, s1_man} + {{MAN_W{1'b0}}, s1_incr};
        exp_sum = s1_exp + {{(EXP_W-1){1'b0}}, man_sum[MAN_W]};
        rm_bad  = (s1_rm > RM_RMM);
        special = (s1_exp == EXP_ONES);
        // A top-magnitude value with the guard set counts as overflow in every mode,
        // even where the mode itself clamps to max finite instead of incrementing.
        ovf     = (exp_sum == EXP_ONES) |
                  ((s1_exp == EXP_MAX_FIN) & (s1_man == MAN_ONES) & s1_g);
        to_max  = (s1_rm == RM_RTZ) | ((s1_rm == RM_RDN) & ~s1_sign) |
                  ((s1_rm == RM_RUP) & s1_sign);
        res_d   = {s1_sign, exp_sum, man_sum[MAN_W-1:0]};
        if (rm_bad) begin
            res_d = QNAN;
        end else if (special) begin
            res_d = {s1_sign, s1_exp, s1_man};
        end else if (ovf) begin
            res_d = to_max ? {s1_sign, EXP_MAX_FIN, MAN_ONES} : {s1_sign, EXP_ONES, {MAN_W{1'b0}}};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s2_res <= '0;
        end else if (s2_load) begin
            s2_res <= res_d;
        end
    end

`ifdef FP_ROUND_PIPE_FLAGS_EN
    logic   s1_inexact;
    flags_t flags_d;
    flags_t s2_flags;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_inexact <= 1'b0;
        end else if (s1_load) begin
            s1_inexact <= |grs_i;
        end
    end

    always_comb begin
        flags_d = '0;
        if (rm_bad) begin
            flags_d[FLAG_NV] = 1'b1;
        end else if (!special) begin
            flags_d[FLAG_NX] = s1_inexact | ovf;
            flags_d[FLAG_OF] = ovf;
            flags_d[FLAG_UF] = (s1_exp == '0) & s1_inexact;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s2_flags <= '0;
        end else if (s2_load) begin
            s2_flags <= flags_d;
        end
    end

    assign flags_o = s2_flags;
`else
    assign flags_o = '0;
`endif

    assign valid_o  = s2_v;
    assign result_o = s2_res;

endmodule

// File: tb/tb_fp_round_pipe.sv
// Directed self-checking bench for fp_round_pipe (EXP_W=8, MAN_W=23).
module tb_fp_round_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic        sign_i = 1'b0;
    logic [7:0]  exp_i = '0;
    logic [22:0] man_i = '0;
    logic [2:0]  grs_i = '0;
    logic [2:0]  rm_i = '0;
    logic        flush_i = 1'b0;
    logic        valid_o;
    logic        ready_i = 1'b1;
    logic [31:0] result_o;
    logic [4:0]  flags_o;

    int n_checks = 0;
    int n_fail = 0;

    fp_round_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .sign_i   (sign_i),
        .exp_i    (exp_i),
        .man_i    (man_i),
        .grs_i    (grs_i),
        .rm_i     (rm_i),
        .flush_i  (flush_i),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .result_o (result_o),
        .flags_o  (flags_o)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] fx(input logic [4:0] f);
`ifdef FP_ROUND_PIPE_FLAGS_EN
        return f;
`else
        return 5'b00000 & f;
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] xp);
        n_checks++;
        assert (obs === xp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, xp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic s, input logic [7:0] e, input logic [22:0] m,
                          input logic [2:0] g, input logic [2:0] r);
        sign_i = s; exp_i = e; man_i = m; grs_i = g; rm_i = r;
    endtask

    task automatic run_vec(input string tag, input logic s, input logic [7:0] e,
                           input logic [22:0] m, input logic [2:0] g, input logic [2:0] r,
                           input logic [31:0] xres, input logic [4:0] xfl);
        int lat;
        set_in(s, e, m, g, r);
        valid_i = 1'b1;
        tick();
        valid_i = 1'b0;
        lat = 1;
        while (!valid_o && lat < 10) begin
            tick();
            lat++;
        end
        check({tag, ".lat"}, lat, 2);
        check({tag, ".res"}, result_o, xres);
        check({tag, ".flags"}, flags_o, fx(xfl));
        tick();
    endtask

    logic [31:0] got [3];
    logic [31:0] held;
    int nrecv;
    int seen;
    logic acc;

    initial begin
        #2;
        check("rst.valid_o", valid_o, 0);
        check("rst.result_o", result_o, 0);
        check("rst.flags_o", flags_o, 0);
        check("rst.ready_o", ready_o, 1);
        tick();
        rst = 1'b0;
        tick();

        run_vec("rne_odd", 1'b0, 8'h7F, 23'h000001, 3'b100, 3'b000, 32'h3F800002, 5'b00001);
        run_vec("rne_carry", 1'b0, 8'h7F, 23'h7FFFFF, 3'b110, 3'b000, 32'h40000000, 5'b00001);
        run_vec("ovf_rne", 1'b0, 8'hFE, 23'h7FFFFF, 3'b100, 3'b000, 32'h7F800000, 5'b00101);
        run_vec("ovf_rtz", 1'b0, 8'hFE, 23'h7FFFFF, 3'b100, 3'b001, 32'h7F7FFFFF, 5'b00101);
        run_vec("rdn_neg", 1'b1, 8'h80, 23'h000000, 3'b001, 3'b010, 32'hC0000001, 5'b00001);
        run_vec("bad_rm", 1'b1, 8'h80, 23'h000000, 3'b001, 3'b110, 32'h7FC00000, 5'b10000);
        run_vec("inf_pass", 1'b1, 8'hFF, 23'h000000, 3'b111, 3'b011, 32'hFF800000, 5'b00000);
        run_vec("uf_rup", 1'b0, 8'h00, 23'h000010, 3'b001, 3'b011, 32'h00000011, 5'b00011);
        run_vec("exact", 1'b0, 8'h85, 23'h123456, 3'b000, 3'b100, 32'h42923456, 5'b00000);

        // Backpressure: three back-to-back operands, downstream stalled 4 cycles.
        ready_i = 1'b0;
        set_in(1'b0, 8'h7F, 23'h000001, 3'b100, 3'b000);
        valid_i = 1'b1;
        check("bp.ready_first", ready_o, 1);
        tick();
        set_in(1'b0, 8'h7F, 23'h7FFFFF, 3'b110, 3'b000);
        tick();
        set_in(1'b1, 8'h80, 23'h000000, 3'b001, 3'b010);
        check("bp.ready_low", ready_o, 0);
        check("bp.valid_held", valid_o, 1);
        held = result_o;
        check("bp.head", held, 32'h3F800002);
        tick();
        tick();
        check("bp.stable", {valid_o, ready_o, result_o}, {1'b1, 1'b0, held});
        ready_i = 1'b1;
        nrecv = 0;
        for (int c = 0; c < 10 && nrecv < 3; c++) begin
            if (valid_o) begin
                got[nrecv] = result_o;
                nrecv++;
            end
            acc = valid_i & ready_o;
            tick();
            if (acc) valid_i = 1'b0;
        end
        check("bp.count", nrecv, 3);
        check("bp.out0", got[0], 32'h3F800002);
        check("bp.out1", got[1], 32'h40000000);
        check("bp.out2", got[2], 32'hC0000001);
        valid_i = 1'b0;
        tick();

        // Flush drops the in-flight operand and the one offered alongside it.
        set_in(1'b0, 8'h7F, 23'h000001, 3'b100, 3'b000);
        valid_i = 1'b1;
        tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        valid_i = 1'b0;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            if (valid_o) seen++;
            tick();
        end
        check("flush.no_out", seen, 0);

        // Asynchronous reset with both stages occupied.
        ready_i = 1'b0;
        valid_i = 1'b1;
        tick();
        tick();
        valid_i = 1'b0;
        check("arst.pre_valid", valid_o, 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst.valid_o", valid_o, 0);
        check("arst.result_o", result_o, 0);
        check("arst.ready_o", ready_o, 1);
        tick();
        rst = 1'b0;
        ready_i = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (valid_o) seen++;
            tick();
        end
        check("arst.no_stale", seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
